main_fsm: RTL and testbench

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/main_fsm_pkg.sv | 38 +++
 rtl/main_fsm_if.sv | 32 +++
 rtl/main_fsm_imm_src_decoder.sv | 17 +
 rtl/main_fsm.sv | 119 +++++++++++
 tb/tb_main_fsm.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes and the
// datapath mux/ALU select codes (the ALU decoder imports the same ALUOp codes).
package main_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/main_fsm_if.sv
// Control bundle between the main FSM (master) and the multicycle datapath (slave).
// Handshake: mem_ready high in a memory-access state means the access completes
// on the coming rising edge; the FSM holds its state and select outputs until then.
interface main_fsm_if;
  logic [6:0] op;
  logic       Zero;
  logic       mem_ready;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic       AdrSrc;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       PCWrite;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, Zero, mem_ready,
    output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
           IRWrite, RegWrite, MemWrite, PCWrite, instr_done, illegal
  );

  modport slave (
    output op, Zero, mem_ready,
    input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
           IRWrite, RegWrite, MemWrite, PCWrite, instr_done, illegal
  );
endinterface

// File: rtl/main_fsm_imm_src_decoder.sv
// Immediate-format select, decoded straight from the opcode in every state.
module imm_src_decoder
  import main_fsm_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);
  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end
endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM. The state register is the only storage; the
// sticky illegal flag is simply "state is TRAP", so reset clears it for free.
module main_fsm
  import main_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  main_fsm_if.master bus,
  output state_t     state
);
  state_t     next_state;
  logic [1:0] imm_src;

  imm_src_decoder u_imm_src_decoder (
    .op      (bus.op),
    .imm_src (imm_src)
  );
  assign bus.ImmSrc = imm_src;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state     = state;
    bus.ALUOp      = ALU_ADD;
    bus.ALUSrcA    = SRCA_PC;
    bus.ALUSrcB    = SRCB_RS2;
    bus.ResultSrc  = RES_ALUOUT;
    bus.AdrSrc     = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    case (state)
      FETCH: begin
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          next_state  = DECODE;
        end
      end
      DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTER;
          OP_IALU:      next_state = EXECUTEI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default:      next_state = TRAP;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        next_state  = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        if (bus.mem_ready) next_state = MEMWB;
      end
      MEMWB: begin
        bus.ResultSrc  = RES_DATA;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        next_state     = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          next_state     = FETCH;
        end
      end
      EXECUTER, EXECUTEI: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = (state == EXECUTEI) ? SRCB_IMM : SRCB_RS2;
        bus.ALUOp   = ALU_FUNCT;
        next_state  = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        next_state     = FETCH;
      end
      BEQ: begin
        bus.ALUSrcA    = SRCA_RS1;
        bus.ALUOp      = ALU_SUB;
        bus.PCWrite    = bus.Zero;
        bus.instr_done = 1'b1;
        next_state     = FETCH;
      end
      JAL: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        bus.PCWrite = 1'b1;
        next_state  = ALUWB;
      end
      TRAP: bus.illegal = 1'b1;
      default: next_state = FETCH;
    endcase
    // Reset wins over everything: no write strobe may fire in a reset cycle.
    if (reset) begin
      bus.IRWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.PCWrite    = 1'b0;
      bus.instr_done = 1'b0;
    end
  end
endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: directed scenarios plus random instruction streams checked
// against a per-instruction model of cycle count and write-strobe totals.
module tb_main_fsm;
  import main_fsm_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;
  int     n_cmp = 0;
  int     n_bad = 0;
  logic [31:0] exp_q[$];

  main_fsm_if bus ();

  main_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic mr, input logic z);
    bus.op        = op;
    bus.mem_ready = mr;
    bus.Zero      = z;
    #2;
  endtask

  function automatic logic [4:0] strobes();
    return {bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.PCWrite, bus.instr_done};
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] op);
    if (op == OP_SW)  return 2'b01;
    if (op == OP_BEQ) return 2'b10;
    if (op == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One random instruction: plan mem_ready per cycle, predict totals, observe.
  task automatic run_random_instr();
    logic [6:0] op;
    logic       z;
    int         kf, km, cycles, pc, mw, rw, sel;
    logic [1:0] rs;
    logic       mr_q[$];
    logic [31:0] e, o;
    int cyc, n_ir, n_pc, n_mw, n_rw, n_done;
    logic [1:0] rs_obs;
    logic seen;

    sel = $urandom_range(0, 5);
    kf  = $urandom_range(0, 3);
    km  = $urandom_range(0, 3);
    z   = 1'($urandom_range(0, 1));
    pc = 1; mw = 0; rw = 0; rs = 2'b00;
    repeat (kf) mr_q.push_back(1'b0);
    mr_q.push_back(1'b1);
    repeat (2) mr_q.push_back(1'($urandom_range(0, 1)));
    case (sel)
      0: begin
        op = OP_LW; rw = 1; rs = 2'b01; cycles = kf + km + 5;
        repeat (km) mr_q.push_back(1'b0);
        mr_q.push_back(1'b1);
        mr_q.push_back(1'($urandom_range(0, 1)));
      end
      1: begin
        op = OP_SW; mw = km + 1; cycles = kf + km + 4;
        repeat (km) mr_q.push_back(1'b0);
        mr_q.push_back(1'b1);
      end
      2, 3: begin
        op = (sel == 2) ? OP_RTYPE : OP_IALU; rw = 1; cycles = kf + 4;
        mr_q.push_back(1'($urandom_range(0, 1)));
      end
      4: begin
        op = OP_BEQ; pc = 1 + int'(z); cycles = kf + 3;
      end
      default: begin
        op = OP_JAL; pc = 2; rw = 1; cycles = kf + 4;
        mr_q.push_back(1'($urandom_range(0, 1)));
      end
    endcase
    e = {2'b00, rs, 4'd1, 4'(rw), 4'(mw), 4'(pc), 4'd1, 8'(cycles)};
    exp_q.push_back(e);

    cyc = 0; n_ir = 0; n_pc = 0; n_mw = 0; n_rw = 0; n_done = 0;
    rs_obs = 2'b00; seen = 1'b0;
    while (!seen && cyc < cycles + 8) begin
      drive(op, (mr_q.size() > 0) ? mr_q.pop_front() : 1'b1, z);
      if (cyc == 0) check("rnd_imm_src", 32'(bus.ImmSrc), 32'(imm_ref(op)));
      n_ir += int'(bus.IRWrite);
      n_pc += int'(bus.PCWrite);
      n_mw += int'(bus.MemWrite);
      n_rw += int'(bus.RegWrite);
      n_done += int'(bus.instr_done);
      if (bus.RegWrite) rs_obs = bus.ResultSrc;
      if (bus.instr_done) seen = 1'b1;
      cyc++;
      tick();
    end
    o = {2'b00, rs_obs, 4'(n_done), 4'(n_rw), 4'(n_mw), 4'(n_pc), 4'(n_ir), 8'(cyc)};
    e = exp_q.pop_front();
    check("rnd_retired", 32'(seen), 32'd1);
    check("rnd_cycles", 32'(o[7:0]), 32'(e[7:0]));
    check("rnd_irwrite", 32'(o[11:8]), 32'(e[11:8]));
    check("rnd_pcwrite", 32'(o[15:12]), 32'(e[15:12]));
    check("rnd_memwrite", 32'(o[19:16]), 32'(e[19:16]));
    check("rnd_regwrite", 32'(o[23:20]), 32'(e[23:20]));
    check("rnd_done", 32'(o[27:24]), 32'(e[27:24]));
    check("rnd_resultsrc", 32'(o[29:28]), 32'(e[29:28]));
    if (!seen) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    state_t lw_seq[5];
    logic   sw_mr[7];
    int     cnt_a, cnt_b;
    lw_seq = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB};
    sw_mr  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Two reset cycles with mem_ready high: no strobes may fire.
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(OP_LW, 1'b1, 1'b0);
      check("reset_strobes", 32'(strobes()), 32'd0);
      tick();
    end
    reset = 1'b0;

    // lw with memory always ready.
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 5; c++) begin
      drive(OP_LW, 1'b1, 1'b0);
      check("lw_state", 32'(dbg_state), 32'(lw_seq[c]));
      if (c == 0) begin
        check("fetch_irwrite", 32'(bus.IRWrite), 32'd1);
        check("fetch_pcwrite", 32'(bus.PCWrite), 32'd1);
        check("fetch_alusrcb", 32'(bus.ALUSrcB), 32'd2);
        check("fetch_illegal", 32'(bus.illegal), 32'd0);
      end
      if (c == 4) begin
        check("lw_regwrite", 32'(bus.RegWrite), 32'd1);
        check("lw_resultsrc", 32'(bus.ResultSrc), 32'd1);
      end else begin
        cnt_a += int'(bus.RegWrite);
      end
      cnt_b += int'(bus.instr_done);
      tick();
    end
    check("lw_early_regwrite", 32'(cnt_a), 32'd0);
    check("lw_done_pulses", 32'(cnt_b), 32'd1);

    // sw with three stalled MEMWRITE cycles.
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 7; c++) begin
      drive(OP_SW, sw_mr[c], 1'b0);
      if (c == 0) check("sw_imm_src", 32'(bus.ImmSrc), 32'd1);
      cnt_a += int'(bus.MemWrite);
      cnt_b += int'(bus.RegWrite);
      tick();
    end
    drive(OP_SW, 1'b0, 1'b0);
    check("sw_memwrite_cycles", 32'(cnt_a), 32'd4);
    check("sw_regwrite", 32'(cnt_b), 32'd0);
    check("sw_back_to_fetch", 32'(dbg_state), 32'(FETCH));

    // beq taken then not taken.
    for (int k = 0; k < 2; k++) begin
      logic z;
      z = (k == 0);
      for (int c = 0; c < 3; c++) begin
        drive(OP_BEQ, 1'b1, z);
        if (c == 2) begin
          check("beq_state", 32'(dbg_state), 32'(BEQ));
          check("beq_aluop", 32'(bus.ALUOp), 32'd1);
          check("beq_pcwrite", 32'(bus.PCWrite), 32'(z));
          check("beq_done", 32'(bus.instr_done), 32'd1);
        end
        tick();
      end
      drive(OP_BEQ, 1'b0, z);
      check("beq_back_to_fetch", 32'(dbg_state), 32'(FETCH));
    end

    // Unsupported opcode traps and holds until reset.
    drive(7'h7F, 1'b1, 1'b0); tick();
    drive(7'h7F, 1'b1, 1'b0); tick();
    cnt_a = 0;
    for (int c = 0; c < 10; c++) begin
      drive(7'h7F, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (dbg_state != TRAP || bus.illegal !== 1'b1 || strobes() !== 5'd0) cnt_a++;
      tick();
    end
    check("trap_hold_bad_cycles", 32'(cnt_a), 32'd0);
    reset = 1'b1;
    drive(7'h7F, 1'b1, 1'b0);
    check("trap_reset_strobes", 32'(strobes()), 32'd0);
    tick();
    reset = 1'b0;
    drive(OP_LW, 1'b0, 1'b0);
    check("trap_reset_state", 32'(dbg_state), 32'(FETCH));
    check("trap_reset_illegal", 32'(bus.illegal), 32'd0);

    // Reset while MEMREAD is stalled.
    for (int c = 0; c < 3; c++) begin
      drive(OP_LW, 1'b1, 1'b0);
      tick();
    end
    reset = 1'b1;
    drive(OP_LW, 1'b0, 1'b0);
    check("memread_state", 32'(dbg_state), 32'(MEMREAD));
    check("memread_reset_regwrite", 32'(bus.RegWrite), 32'd0);
    tick();
    reset = 1'b0;
    drive(OP_LW, 1'b0, 1'b0);
    check("memread_reset_state", 32'(dbg_state), 32'(FETCH));
    check("memread_reset_regwrite2", 32'(bus.RegWrite), 32'd0);

    // Random instruction stream; DUT sits in FETCH with mem_ready low here.
    repeat (40) run_random_instr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
